dna_serial_desc: RTL and testbench
==================================

Name: dna_serial_desc

Overview:
- Consumes the 57-bit device DNA from the DNA reader and produces the USB serial-number string descriptor as a byte stream.
- The descriptor is bLength, bDescriptorType, then 15 hex digits encoded as UTF-16LE.
- Sits between the DNA reader and the USB control-endpoint IN data path.
- Handles truncation to the host-requested length (wLength) and stream backpressure.

Parameters:
UPPERCASE, 1, 1: hex letters are 'A'-'F' (0x41-0x46); 0: 'a'-'f' (0x61-0x66)
DESC_TYPE, 8'h03, value emitted as bDescriptorType

Ports:
clk_48  input  1  system clock, 48 MHz
rst  input  1  asynchronous reset, active-high
dna  input  57  device DNA from the reader; valid while dna_ready=1
dna_ready  input  1  DNA read complete
start  input  1  single-cycle request to emit the descriptor; sampled only in IDLE
req_len  input  8  host wLength (low byte); sampled with start
abort  input  1  synchronous cancel (e.g. SETUP received or bus reset)
out_data  output  8  descriptor byte
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts the byte
out_last  output  1  marks the final byte of the transfer
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when a transfer completes normally

Behaviour:
- Reset (async): state=IDLE; out_valid=0, out_data=8'h00, out_last=0, busy=0, done=0; snapshot and counters=0.
- Descriptor is always 32 bytes:
  - byte0 = 8'd32 (bLength = 32 even when truncated)
  - byte1 = DESC_TYPE
  - bytes 2k+2 / 2k+3, k=0..14: ASCII of nibble (14-k), then 8'h00
  - nibble 14 = {3'b000, dna[56]}; nibble i = dna[4i+3:4i] for i=0..13 (most significant digit first)
  - Digit 0-9 → 0x30-0x39; 10-15 → letters per UPPERCASE.
- Effective length: len = min(req_len, 32), 8-bit compare.
- States and transitions:
  - IDLE:
    - start=1 and dna_ready=1 → copy dna to the 57-bit snapshot; go to SEND.
    - start=1 and dna_ready=0 → go to WAIT.
    - start=1 and req_len=0 → no bytes; done=1 next cycle; stay IDLE. This check takes priority over dna_ready.
  - WAIT: on dna_ready=1, copy the snapshot and go to SEND. Stays in WAIT indefinitely otherwise.
  - SEND:
    - byte index idx counts 0..len-1.
    - out_valid=1 with out_data = byte[idx]; out_last = (idx==len-1).
    - Transfer occurs when out_valid && out_ready; idx increments on each transfer.
    - On the last transfer: next cycle out_valid=0, out_last=0, done=1 for one cycle, state=IDLE, busy=0.
- Latency: start in cycle N with dna_ready=1 → out_valid=1 with byte0 in cycle N+1. One byte per cycle while out_ready is held high.
- Output registers:
  - out_data and out_last come from registers.
  - While out_valid && !out_ready, out_data and out_last are held stable.
  - out_valid never drops without a transfer, except on abort or reset.
- All bytes come from the snapshot; dna or dna_ready changing during SEND has no effect.
- start while busy is ignored, including a start arriving in the same cycle as the final transfer.
- abort in any state:
  - Next cycle: IDLE, out_valid=0, out_last=0, done=0, busy=0.
  - abort overrides a coincident transfer, start or dna_ready.
- Reset mid-transfer: immediate return to reset values; no done pulse.

Test Plan:
- dna=57'h123456789ABCDEF, dna_ready=1, req_len=64, out_ready=1 → 32 bytes on consecutive cycles: 20 03 31 00 32 00 … 45 00 46 00; out_last only on byte 31; done 1 cycle later; busy low.
- Same DNA, req_len=4 → bytes 20 03 31 00, out_last on 31 00's high byte (4th byte); then req_len=0 → no out_valid, done pulse in cycle N+1.
- UPPERCASE=0, dna=57'h0_0000_0000_0000_0AF → digits 30 00 ×13, then 61 00 66 00 → leading zeros kept, lowercase letters.
- start with dna_ready=0; raise dna_ready 100 cycles later → first byte 20 appears 1 cycle after dna_ready; busy high throughout WAIT.
- out_ready random (~50%) with dna changed during SEND → byte sequence identical to the out_ready=1 case; out_data held stable while stalled; output matches the snapshot taken before the change.
- abort asserted at idx=10 while stalled → out_valid=0 next cycle, no done pulse; a following start emits a full fresh descriptor beginning with 20 03.

Source files
------------

// File: rtl/dna_serial_desc.sv
// Streams the USB serial-number string descriptor built from the 57-bit device DNA.
// Bytes are generated from a registered DNA snapshot and presented on a valid/ready byte stream.
module dna_serial_desc #(
    parameter bit         UPPERCASE = 1'b1,
    parameter logic [7:0] DESC_TYPE = 8'h03
) (
    input  logic        clk_48,
    input  logic        rst,
    input  logic [56:0] dna,
    input  logic        dna_ready,
    input  logic        start,
    input  logic [7:0]  req_len,
    input  logic        abort,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_t;

    state_t      state, state_n;
    logic [56:0] snap, snap_n;
    logic [5:0]  len, len_n;
    logic [5:0]  idx, idx_n;
    logic [5:0]  idx_inc;
    logic [5:0]  req_eff;
    logic [7:0]  data_n;
    logic        valid_n;
    logic        last_n;
    logic        done_n;
    logic        xfer;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    // Even bytes from 2 up carry digit 15-b/2, so the top nibble goes out first.
    function automatic logic [7:0] desc_byte(
        input logic [56:0] s,
        input logic [4:0]  b
    );
        logic [59:0] ext;
        logic [3:0]  ni;
        ext = {3'b000, s};
        ni  = 4'd15 - b[4:1];
        if (b == 5'd0)
            return 8'd32;
        if (b == 5'd1)
            return DESC_TYPE;
        if (b[0])
            return 8'h00;
        return hex_ascii(ext[{ni, 2'b00} +: 4]);
    endfunction

    assign req_eff = (req_len > 8'd32) ? 6'd32 : req_len[5:0];
    assign idx_inc = idx + 6'd1;
    assign xfer    = out_valid && out_ready;
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        snap_n  = snap;
        len_n   = len;
        idx_n   = idx;
        data_n  = out_data;
        valid_n = out_valid;
        last_n  = out_last;
        done_n  = 1'b0;
        if (abort) begin
            state_n = IDLE;
            idx_n   = 6'd0;
            valid_n = 1'b0;
            last_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (req_len == 8'd0) begin
                            done_n = 1'b1;
                        end else begin
                            len_n = req_eff;
                            idx_n = 6'd0;
                            if (dna_ready) begin
                                snap_n  = dna;
                                state_n = SEND;
                                valid_n = 1'b1;
                                data_n  = 8'd32;
                                last_n  = (req_eff == 6'd1);
                            end else begin
                                state_n = WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (dna_ready) begin
                        snap_n  = dna;
                        state_n = SEND;
                        valid_n = 1'b1;
                        data_n  = 8'd32;
                        last_n  = (len == 6'd1);
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (out_last) begin
                            state_n = IDLE;
                            idx_n   = 6'd0;
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            idx_n  = idx_inc;
                            data_n = desc_byte(snap, idx_inc[4:0]);
                            last_n = (idx_inc == len - 6'd1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            len       <= '0;
            idx       <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            snap      <= snap_n;
            len       <= len_n;
            idx       <= idx_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_dna_serial_desc.sv
// Bench for dna_serial_desc: random DNA and backpressure checked against a string-based model.
module tb_dna_serial_desc;

    logic clk_48 = 1'b0;
    always #10 clk_48 = ~clk_48;

    logic        rst;
    logic [56:0] dna;
    logic        dna_ready;
    logic        start;
    logic [7:0]  req_len;
    logic        abort;
    logic        out_ready;

    logic [7:0] data_u, data_l;
    logic       valid_u, valid_l, last_u, last_l;
    logic       busy_u, busy_l, done_u, done_l;

    bit sel_lo;
    wire [7:0] o_data  = sel_lo ? data_l  : data_u;
    wire       o_valid = sel_lo ? valid_l : valid_u;
    wire       o_last  = sel_lo ? last_l  : last_u;
    wire       o_busy  = sel_lo ? busy_l  : busy_u;
    wire       o_done  = sel_lo ? done_l  : done_u;

    dna_serial_desc #(.UPPERCASE(1'b1), .DESC_TYPE(8'h03)) u_up (
        .clk_48(clk_48), .rst(rst), .dna(dna), .dna_ready(dna_ready),
        .start(start), .req_len(req_len), .abort(abort),
        .out_data(data_u), .out_valid(valid_u), .out_ready(out_ready),
        .out_last(last_u), .busy(busy_u), .done(done_u)
    );

    dna_serial_desc #(.UPPERCASE(1'b0), .DESC_TYPE(8'h03)) u_lo (
        .clk_48(clk_48), .rst(rst), .dna(dna), .dna_ready(dna_ready),
        .start(start), .req_len(req_len), .abort(abort),
        .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
        .out_last(last_l), .busy(busy_l), .done(done_l)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int last_cnt, last_pos, first_lat, end_cyc;
    bit stall_bad, tmo;

    // Reference: format the DNA as 15 hex characters, then UTF-16LE them.
    function automatic void build_exp(
        input logic [56:0] d,
        input logic [7:0]  rl,
        input bit          up
    );
        logic [59:0] v;
        string       s;
        logic [7:0]  c;
        logic [7:0]  full[$];
        int          n;
        v = {3'b000, d};
        s = $sformatf("%h", v);
        full = {};
        full.push_back(8'd32);
        full.push_back(8'h03);
        for (int i = 0; i < 15; i++) begin
            c = s[i];
            if (up && c >= 8'h61)
                c = c - 8'd32;
            full.push_back(c);
            full.push_back(8'h00);
        end
        n = (rl > 8'd32) ? 32 : int'(rl);
        exp_q = {};
        for (int i = 0; i < n; i++)
            exp_q.push_back(full[i]);
    endfunction

    function automatic int first_diff();
        if (got_q.size() != exp_q.size())
            return -2;
        foreach (got_q[i])
            if (got_q[i] !== exp_q[i])
                return i;
        return -1;
    endfunction

    task automatic kick(input logic [7:0] rl);
        @(negedge clk_48);
        start   = 1'b1;
        req_len = rl;
        @(negedge clk_48);
        start   = 1'b0;
        req_len = 8'($urandom);
    endtask

    // Collects bytes until the out_last transfer; returns at that negedge.
    task automatic capture(input bit rnd, input bit chg);
        logic [7:0] hd;
        logic       hl;
        bit         stalled;
        got_q = {};
        last_cnt = 0; last_pos = -1; first_lat = -1; end_cyc = -1;
        stall_bad = 1'b0; tmo = 1'b1; stalled = 1'b0;
        hd = 8'h00; hl = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0)
                @(negedge clk_48);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (chg)
                dna = 57'({$urandom(), $urandom()});
            if (o_valid && first_lat < 0)
                first_lat = cyc;
            if (stalled && (!o_valid || o_data !== hd || o_last !== hl))
                stall_bad = 1'b1;
            stalled = o_valid && !out_ready;
            hd = o_data;
            hl = o_last;
            if (o_valid && out_ready) begin
                got_q.push_back(o_data);
                if (o_last) begin
                    last_cnt++;
                    last_pos = got_q.size() - 1;
                    end_cyc = cyc;
                    tmo = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_48);
        checks++;
        if ({data_u, valid_u, last_u, busy_u, done_u} !== 12'h000 ||
            {data_l, valid_l, last_l, busy_l, done_l} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got %h/%h required 000/000",
                     {data_u, valid_u, last_u, busy_u, done_u},
                     {data_l, valid_l, last_l, busy_l, done_l});
        end
        rst = 1'b0;
    endtask

    task automatic test_full();
        int d;
        dna = 57'h123456789ABCDEF;
        dna_ready = 1'b1;
        build_exp(dna, 8'd64, 1'b1);
        kick(8'd64);
        capture(1'b0, 1'b0);
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL full_bytes: diff %0d got %p required %p", d, got_q, exp_q);
        end
        checks++;
        if (tmo || got_q.size() != 32 || got_q[30] !== 8'h46 || got_q[2] !== 8'h31) begin
            errors++;
            $display("FAIL full_known: size %0d required 32 (tmo %0d)", got_q.size(), tmo);
        end
        checks++;
        if (first_lat != 0 || end_cyc != 31) begin
            errors++;
            $display("FAIL full_timing: first %0d end %0d required 0 31", first_lat, end_cyc);
        end
        checks++;
        if (last_cnt != 1 || last_pos != 31) begin
            errors++;
            $display("FAIL full_last: pos %0d required 31", last_pos);
        end
        @(negedge clk_48);
        checks++;
        if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL full_done: done %b valid %b busy %b required 1 0 0",
                     o_done, o_valid, o_busy);
        end
        @(negedge clk_48);
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse: done %b required 0", o_done);
        end
    endtask

    task automatic test_trunc();
        logic [7:0] lens[5];
        int d;
        dna = 57'h123456789ABCDEF;
        build_exp(dna, 8'd4, 1'b1);
        kick(8'd4);
        capture(1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || last_pos != 3) begin
            errors++;
            $display("FAIL trunc4: got %p last %0d required %p last 3", got_q, last_pos, exp_q);
        end
        repeat (2) @(negedge clk_48);
        kick(8'd0);
        checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL len0: valid %b done %b required 0 1", o_valid, o_done);
        end
        @(negedge clk_48);
        checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_after: valid %b done %b busy %b required 0 0 0",
                     o_valid, o_done, o_busy);
        end
        lens = '{8'd1, 8'd31, 8'd32, 8'd33, 8'd255};
        foreach (lens[i]) begin
            dna = 57'({$urandom(), $urandom()});
            build_exp(dna, lens[i], 1'b1);
            kick(lens[i]);
            capture(1'b1, 1'b0);
            d = first_diff();
            checks++;
            if (d != -1 || tmo || last_pos != exp_q.size() - 1) begin
                errors++;
                $display("FAIL trunc_len%0d: diff %0d last %0d got %p required %p",
                         lens[i], d, last_pos, got_q, exp_q);
            end
            repeat (2) @(negedge clk_48);
        end
    endtask

    task automatic test_lower();
        sel_lo = 1'b1;
        dna = 57'h0AF;
        build_exp(dna, 8'd32, 1'b0);
        kick(8'd32);
        capture(1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || got_q.size() != 32 ||
            got_q[28] !== 8'h61 || got_q[30] !== 8'h66 || got_q[26] !== 8'h30) begin
            errors++;
            $display("FAIL lower_bytes: got %p required %p", got_q, exp_q);
        end
        repeat (2) @(negedge clk_48);
        sel_lo = 1'b0;
    endtask

    task automatic test_wait();
        bit bad;
        dna_ready = 1'b0;
        dna = 57'h0;
        kick(8'd32);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!o_busy || o_valid)
                bad = 1'b1;
            @(negedge clk_48);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wait_busy: busy or valid wrong during wait, required busy 1 valid 0");
        end
        dna = 57'({$urandom(), $urandom()});
        dna_ready = 1'b1;
        build_exp(dna, 8'd32, 1'b1);
        @(negedge clk_48);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h20) begin
            errors++;
            $display("FAIL wait_first: valid %b data %h required 1 20", o_valid, o_data);
        end
        capture(1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || tmo) begin
            errors++;
            $display("FAIL wait_bytes: got %p required %p", got_q, exp_q);
        end
        repeat (2) @(negedge clk_48);
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 3; r++) begin
            dna = (r == 0) ? 57'h123456789ABCDEF : 57'({$urandom(), $urandom()});
            build_exp(dna, 8'd64, 1'b1);
            kick(8'd64);
            capture(1'b1, 1'b1);
            checks++;
            if (first_diff() != -1 || tmo) begin
                errors++;
                $display("FAIL bp_bytes%0d: got %p required %p", r, got_q, exp_q);
            end
            checks++;
            if (stall_bad) begin
                errors++;
                $display("FAIL bp_stable%0d: output changed while stalled, required held", r);
            end
            @(negedge clk_48);
            checks++;
            if (o_done !== 1'b1 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_done%0d: done %b valid %b required 1 0", r, o_done, o_valid);
            end
            @(negedge clk_48);
        end
    endtask

    task automatic test_back_to_back();
        dna = 57'({$urandom(), $urandom()});
        kick(8'd4);
        capture(1'b0, 1'b0);
        start = 1'b1;
        req_len = 8'd32;
        @(negedge clk_48);
        start = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done %b busy %b valid %b required 1 0 0",
                     o_done, o_busy, o_valid);
        end
        @(negedge clk_48);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored_start: valid %b busy %b required 0 0", o_valid, o_busy);
        end
        build_exp(dna, 8'd20, 1'b1);
        start = 1'b1;
        req_len = 8'd20;
        @(negedge clk_48);
        start = 1'b0;
        capture(1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || tmo) begin
            errors++;
            $display("FAIL b2b_next: got %p required %p", got_q, exp_q);
        end
        repeat (2) @(negedge clk_48);
    endtask

    task automatic test_abort();
        int n;
        dna = 57'({$urandom(), $urandom()});
        build_exp(dna, 8'd32, 1'b1);
        kick(8'd32);
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            if (c > 0)
                @(negedge clk_48);
            out_ready = 1'b1;
            if (o_valid)
                n++;
        end
        @(negedge clk_48);
        out_ready = 1'b0;
        @(negedge clk_48);
        checks++;
        if (o_valid !== 1'b1 || o_data !== exp_q[10]) begin
            errors++;
            $display("FAIL abort_stall: valid %b data %h required 1 %h", o_valid, o_data, exp_q[10]);
        end
        abort = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk_48);
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: valid %b done %b busy %b required 0 0 0",
                     o_valid, o_done, o_busy);
        end
        @(negedge clk_48);
        checks++;
        if (o_done !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: done %b valid %b required 0 0", o_done, o_valid);
        end
        dna = 57'({$urandom(), $urandom()});
        build_exp(dna, 8'd32, 1'b1);
        kick(8'd32);
        capture(1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || tmo || got_q[0] !== 8'h20 || got_q[1] !== 8'h03) begin
            errors++;
            $display("FAIL abort_fresh: got %p required %p", got_q, exp_q);
        end
        repeat (2) @(negedge clk_48);
    endtask

    task automatic test_reset_mid();
        dna = 57'({$urandom(), $urandom()});
        kick(8'd32);
        repeat (5) @(negedge clk_48);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_data, o_valid, o_last, o_busy, o_done} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: got %h required 000", {o_data, o_valid, o_last, o_busy, o_done});
        end
        @(negedge clk_48);
        rst = 1'b0;
        @(negedge clk_48);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: done %b busy %b valid %b required 0 0 0",
                     o_done, o_busy, o_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        dna = '0;
        dna_ready = 1'b0;
        start = 1'b0;
        req_len = 8'd0;
        abort = 1'b0;
        out_ready = 1'b1;
        sel_lo = 1'b0;
        test_reset();
        test_full();
        test_trunc();
        test_lower();
        test_wait();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
